sync_frame_deserializer: RTL



---
 rtl/sync_frame_deserializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sync_frame_deserializer.sv
// Frame capture stage behind the 10000001 sync detector: after each sync it
// shifts in a WIDTH-bit MSB-first payload plus an even-parity bit and presents it.
module sync_frame_deserializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             J,
    input  logic             Y,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             parity_err,
    output logic             resync,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BC_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state_r, state_nx_s;
    logic [WIDTH-1:0] sr_r, sr_nx_s;
    logic [BC_W-1:0]  bc_r, bc_nx_s;
    logic             p_r, p_nx_s;
    logic [WIDTH-1:0] data_nx_s;
    logic             valid_nx_s;
    logic             perr_nx_s;
    logic             resync_nx_s;
    logic             busy_nx_s;
    logic [CNT_W-1:0] cnt_nx_s;

    function automatic logic parity_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    // Next-state and next-output logic; a sync always restarts capture, whatever the state.
    always_comb begin
        state_nx_s  = state_r;
        sr_nx_s     = sr_r;
        bc_nx_s     = bc_r;
        p_nx_s      = p_r;
        data_nx_s   = data_out;
        valid_nx_s  = 1'b0;
        perr_nx_s   = parity_err;
        resync_nx_s = 1'b0;
        cnt_nx_s    = frame_cnt;
        if (Y) begin
            sr_nx_s     = {sr_r[WIDTH-2:0], J};
            bc_nx_s     = BC_W'(1);
            p_nx_s      = J;
            state_nx_s  = SHIFT;
            resync_nx_s = (state_r != HUNT) ? 1'b1 : 1'b0;
        end else begin
            case (state_r)
                HUNT: begin
                    state_nx_s = HUNT;
                end
                SHIFT: begin
                    sr_nx_s = {sr_r[WIDTH-2:0], J};
                    bc_nx_s = bc_r + BC_W'(1);
                    p_nx_s  = parity_step(p_r, J);
                    if (bc_nx_s == BC_W'(WIDTH)) begin
                        state_nx_s = PAR;
                    end else begin
                        state_nx_s = SHIFT;
                    end
                end
                PAR: begin
                    data_nx_s  = sr_r;
                    perr_nx_s  = parity_step(p_r, J);
                    valid_nx_s = 1'b1;
                    state_nx_s = HUNT;
                    // Bad-parity frames are still presented but not counted.
                    if (!perr_nx_s) begin
                        cnt_nx_s = frame_cnt + CNT_W'(1);
                    end else begin
                        cnt_nx_s = frame_cnt;
                    end
                end
                default: begin
                    state_nx_s = HUNT;
                end
            endcase
        end
        busy_nx_s = (state_nx_s != HUNT) ? 1'b1 : 1'b0;
    end

    // State, datapath and registered outputs with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= HUNT;
            sr_r       <= '0;
            bc_r       <= '0;
            p_r        <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            resync     <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state_r    <= state_nx_s;
            sr_r       <= sr_nx_s;
            bc_r       <= bc_nx_s;
            p_r        <= p_nx_s;
            data_out   <= data_nx_s;
            valid      <= valid_nx_s;
            parity_err <= perr_nx_s;
            resync     <= resync_nx_s;
            busy       <= busy_nx_s;
            frame_cnt  <= cnt_nx_s;
        end
    end

endmodule
